// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared state type and default psum widths for the PE column
package psum_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} psum_col_state_t;
   localparam int PSUM_ACC_W = 20;
   localparam int PSUM_OUT_W = 24;
endpackage

// File: rtl/psum_acc_buf.sv
// rtl/psum_acc_buf.sv - DEPTH x OUT_WIDTH accumulator buffer, read-modify-write port plus read port
module psum_acc_buf #(
   parameter int OUT_WIDTH = 24,
   parameter int DEPTH     = 16,
   parameter int IDX_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic                 wr_first,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [OUT_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [OUT_WIDTH-1:0] rd_data
);
   logic [OUT_WIDTH-1:0] mem [DEPTH];

   // First pass overwrites stale tile data; later passes add, wrapping modulo 2^OUT_WIDTH.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_first) mem[wr_idx] <= wr_data;
         else          mem[wr_idx] <= mem[wr_idx] + wr_data;
      end
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - psum accumulate/drain FSM; PSUM_COLLECTOR_RELU_EN clamps negative drained words to 0
module psum_collector
   import psum_pkg::*;
#(
   parameter int ACC_WIDTH  = PSUM_ACC_W,
   parameter int OUT_WIDTH  = PSUM_OUT_W,
   parameter int DEPTH      = 16,
   parameter int PASS_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [PASS_WIDTH-1:0]       cfg_passes,
   input  logic                        psum_valid,
   input  logic signed [ACC_WIDTH-1:0] psum_in,
   input  logic                        psum_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_WIDTH-1:0]        out_data,
   output logic                        out_last,
   output logic                        busy,
   output logic                        err
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   psum_col_state_t       state;
   logic [PASS_WIDTH-1:0] passes, pass_cnt;
   logic [CNT_W-1:0]      wr_idx, wr_inc, len;
   logic [IDX_W-1:0]      rd_idx;
   logic [OUT_WIDTH-1:0]  ext, rd_data;
   logic                  full, wr_en;

   assign ext    = OUT_WIDTH'(psum_in);
   assign full   = (wr_idx == CNT_W'(DEPTH));
   assign wr_inc = wr_idx + CNT_W'(1);
   assign wr_en  = (state == ACCUM) && psum_valid && !full;

   psum_acc_buf #(.OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_buf (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_first (pass_cnt == '0),
      .wr_idx   (wr_idx[IDX_W-1:0]),
      .wr_data  (ext),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         passes   <= '0;
         pass_cnt <= '0;
         wr_idx   <= '0;
         len      <= '0;
         rd_idx   <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  passes   <= (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
                  pass_cnt <= '0;
                  wr_idx   <= '0;
                  len      <= '0;
                  err      <= 1'b0;
                  state    <= ACCUM;
               end else if (psum_valid) begin
                  err <= 1'b1;
               end
            end
            ACCUM: begin
               if (psum_valid) begin
                  if (full) err <= 1'b1;
                  if (psum_last) begin
                     // Pass 0 defines the tile length; later passes must match it.
                     if (pass_cnt == '0)  len <= full ? CNT_W'(DEPTH) : wr_inc;
                     else if (wr_inc != len) err <= 1'b1;
                     wr_idx   <= '0;
                     pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                     if (pass_cnt == passes - PASS_WIDTH'(1)) begin
                        rd_idx <= '0;
                        state  <= DRAIN;
                     end
                  end else if (!full) begin
                     wr_idx <= wr_inc;
                  end
               end
            end
            DRAIN: begin
               if (psum_valid) err <= 1'b1;
               if (out_ready) begin
                  if (out_last) state  <= IDLE;
                  else          rd_idx <= rd_idx + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign out_last  = out_valid && (CNT_W'(rd_idx) == len - CNT_W'(1));

`ifdef PSUM_COLLECTOR_RELU_EN
   assign out_data = rd_data[OUT_WIDTH-1] ? '0 : rd_data;
`else
   assign out_data = rd_data;
`endif
endmodule
